// File: rtl/cache_refill_buffer.sv
// rtl/cache_refill_buffer.sv - line-fill buffer: one block read request, beat collection, one-shot array write
// The missed word is forwarded to the CPU the cycle after its beat is accepted.
module cache_refill_buffer #(
  parameter int WORD_W  = 32,
  parameter int WORDS   = 16,
  parameter int INDEX_W = 7,
  parameter int WAY_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_start,
  input  logic [ADDR_W-1:0]       fill_addr,
  input  logic [WAY_W-1:0]        fill_way,
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic                    fill_error,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_rdata_valid,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    mem_rdata_last,
  output logic                    mem_rdata_ready,
  output logic                    cpu_word_valid,
  output logic [WORD_W-1:0]       cpu_word_data,
  output logic                    arr_write_en_block,
  output logic [INDEX_W-1:0]      arr_index,
  output logic [WAY_W-1:0]        arr_way_select,
  output logic [WORDS*WORD_W-1:0] arr_block_data
);

  localparam int CNT_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int OFF_W  = CNT_W + BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE,
    S_ERR
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_word;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  logic                    r_req_valid;
  logic [ADDR_W-1:0]       r_req_addr;
  logic                    r_rdata_ready;
  logic                    r_cpu_valid;
  logic [WORD_W-1:0]       r_cpu_data;
  logic                    r_wr_en;
  logic [INDEX_W-1:0]      r_index;
  logic [WAY_W-1:0]        r_way;
  logic [WORDS*WORD_W-1:0] r_line;

  logic w_beat;
  logic w_at_end;
  logic w_crit;
  logic w_unused_byte;

  assign w_beat        = (r_state == S_FILL) && mem_rdata_valid && r_rdata_ready;
  assign w_at_end      = (r_cnt == CNT_W'(WORDS - 1));
  assign w_crit        = w_beat && (r_cnt == r_word);
  // Byte offset within a word carries no meaning for a block fill.
  assign w_unused_byte = ^fill_addr[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_word        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_rdata_ready <= 1'b0;
      r_cpu_valid   <= 1'b0;
      r_cpu_data    <= '0;
      r_wr_en       <= 1'b0;
      r_index       <= '0;
      r_way         <= '0;
      r_line        <= '0;
    end else begin
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_cpu_valid <= 1'b0;

      if (w_crit) begin
        r_cpu_valid <= 1'b1;
        r_cpu_data  <= mem_rdata;
      end

      if (w_beat) begin
        r_line[r_cnt*WORD_W +: WORD_W] <= mem_rdata;
        r_cnt                          <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (fill_start) begin
            r_req_addr  <= {fill_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_index     <= fill_addr[OFF_W +: INDEX_W];
            r_way       <= fill_way;
            r_word      <= fill_addr[BYTE_W +: CNT_W];
            r_cnt       <= '0;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_req_valid   <= 1'b0;
            r_rdata_ready <= 1'b1;
            r_state       <= S_FILL;
          end
        end
        S_FILL: begin
          // A last flag off the final beat, or a final beat without one, aborts the fill.
          if (w_beat && (mem_rdata_last || w_at_end)) begin
            r_rdata_ready <= 1'b0;
            if (mem_rdata_last && w_at_end) begin
              r_wr_en <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_WRITE, S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy        <= 1'b0;
          r_req_valid   <= 1'b0;
          r_rdata_ready <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign fill_busy          = r_busy;
  assign fill_done          = r_done;
  assign fill_error         = r_error;
  assign mem_req_valid      = r_req_valid;
  assign mem_req_addr       = r_req_addr;
  assign mem_rdata_ready    = r_rdata_ready;
  assign cpu_word_valid     = r_cpu_valid;
  assign cpu_word_data      = r_cpu_data;
  assign arr_write_en_block = r_wr_en;
  assign arr_index          = r_index;
  assign arr_way_select     = r_way;
  assign arr_block_data     = r_line;

endmodule

// File: tb/tb_cache_refill_buffer.sv
// tb/tb_cache_refill_buffer.sv - scoreboard bench for cache_refill_buffer
// Stimulus pushes expected requests, CPU words, writes and errors; a negedge monitor pops and compares.
module tb_cache_refill_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fill_start = 1'b0;
  logic [31:0]  fill_addr = '0;
  logic [1:0]   fill_way = '0;
  logic         fill_busy, fill_done, fill_error;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rdata_valid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rdata_last = 1'b0;
  logic         mem_rdata_ready;
  logic         cpu_word_valid;
  logic [31:0]  cpu_word_data;
  logic         arr_write_en_block;
  logic [6:0]   arr_index;
  logic [1:0]   arr_way_select;
  logic [511:0] arr_block_data;

  cache_refill_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_way(fill_way),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rdata_last(mem_rdata_last),
    .mem_rdata_ready(mem_rdata_ready),
    .cpu_word_valid(cpu_word_valid), .cpu_word_data(cpu_word_data),
    .arr_write_en_block(arr_write_en_block), .arr_index(arr_index),
    .arr_way_select(arr_way_select), .arr_block_data(arr_block_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   idx;
    logic [1:0]   way;
    logic [511:0] line;
    bit           crit_same;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pend_err = 0;
  int          n_req_rise = 0;
  bit          prev_req = 1'b0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_cpu[$];
  wr_t         exp_wr[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_req_valid && !prev_req) n_req_rise++;
    prev_req = mem_req_valid;
    if (mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
      else chk("req_addr", mem_req_addr, exp_req.pop_front());
    end
    if (cpu_word_valid) begin
      if (exp_cpu.size() == 0) chk("unexpected_cpu_word", 1, 0);
      else chk("cpu_word_data", cpu_word_data, exp_cpu.pop_front());
    end
    if (arr_write_en_block) begin
      if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_wr.pop_front();
        chk("arr_index", arr_index, e.idx);
        chk("arr_way", arr_way_select, e.way);
        chk("arr_block_data", arr_block_data, e.line);
        chk("done_with_write", fill_done, 1);
        chk("cpu_valid_at_write", cpu_word_valid, e.crit_same);
      end
    end else if (fill_done) begin
      chk("done_without_write", 1, 0);
    end
    if (fill_error) begin
      if (pend_err == 0) chk("unexpected_error", 1, 0);
      else begin
        pend_err--;
        chk("no_write_on_error", arr_write_en_block, 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {fill_busy, fill_done, fill_error, mem_req_valid, mem_rdata_ready,
                          cpu_word_valid, arr_write_en_block}, 0);
    chk({tag, "_req_addr"}, mem_req_addr, 0);
    chk({tag, "_cpu_data"}, cpu_word_data, 0);
    chk({tag, "_index_way"}, {arr_index, arr_way_select}, 0);
    chk({tag, "_block"}, arr_block_data, 0);
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [1:0] way,
                          input logic [31:0] exp_aligned, input logic [6:0] exp_idx,
                          input logic [3:0] exp_word, input logic [31:0] base,
                          input bit toggle, input int last_at, input int req_delay, input bit hold);
    int   nbeats;
    wr_t  e;
    nbeats = (last_at < 0) ? 16 : last_at + 1;
    exp_req.push_back(exp_aligned);
    if (int'(exp_word) < nbeats) exp_cpu.push_back(base + 32'(exp_word));
    if (last_at == 15) begin
      e.idx = exp_idx;
      e.way = way;
      e.crit_same = (exp_word == 4'hF);
      for (int k = 0; k < 16; k++) e.line[k*32 +: 32] = base + 32'(k);
      exp_wr.push_back(e);
    end else begin
      pend_err++;
    end

    fill_addr = addr;
    fill_way = way;
    fill_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) fill_start = 1'b0;
    chk("req_valid_after_start", mem_req_valid, 1);
    chk("busy_in_req", fill_busy, 1);
    // Garbage beats during REQ must be ignored.
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    mem_rdata_last = 1'b1;
    repeat (req_delay) begin
      @(posedge clk); #1;
      chk("req_held", {mem_req_valid, mem_req_addr}, {1'b1, exp_aligned});
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata_last = 1'b0;

    for (int k = 0; k < nbeats; k++) begin
      if (toggle && k > 0) begin
        mem_rdata_valid = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        mem_rdata_last = 1'b1;
        @(posedge clk); #1;
        chk("busy_idle_beat", fill_busy, 1);
      end
      mem_rdata_valid = 1'b1;
      mem_rdata = base + 32'(k);
      mem_rdata_last = (k == last_at);
      @(posedge clk); #1;
      chk("busy_in_fill", fill_busy, 1);
      chk("no_req_in_fill", mem_req_valid, 0);
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last = 1'b0;
    if (last_at == 15) chk("write_strobe_n1", arr_write_en_block, 1);
    else chk("error_pulse_n1", fill_error, 1);
    @(posedge clk); #1;
    chk("idle_n2", {fill_busy, mem_req_valid}, 0);
  endtask

  initial begin : stim
    int rises;
    #2;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic fill, then same fill with beat gaps
    run_fill(32'h0000_1F48, 2'd3, 32'h0000_1F40, 7'h7D, 4'd2, 32'h100, 1'b0, 15, 2, 1'b0);
    run_fill(32'h0000_1F48, 2'd3, 32'h0000_1F40, 7'h7D, 4'd2, 32'h100, 1'b1, 15, 2, 1'b0);
    // early last, then recovery, then missing last on final beat
    run_fill(32'h0000_0A14, 2'd1, 32'h0000_0A00, 7'h28, 4'd5, 32'h200, 1'b0, 9, 0, 1'b0);
    run_fill(32'h0001_FFC0, 2'd0, 32'h0001_FFC0, 7'h7F, 4'd0, 32'h400, 1'b0, 15, 1, 1'b0);
    run_fill(32'h0000_0040, 2'd2, 32'h0000_0040, 7'h01, 4'd0, 32'h500, 1'b0, -1, 0, 1'b0);

    // reset mid-fill after beat 6
    exp_req.push_back(32'h0000_1F40);
    exp_cpu.push_back(32'h302);
    fill_addr = 32'h0000_1F48;
    fill_way = 2'd1;
    fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'h300 + 32'(k);
      @(posedge clk); #1;
    end
    mem_rdata_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("reset_midfill");
    @(posedge clk); #1;
    check_zero("reset_midfill_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_fill(32'h8000_1234, 2'd2, 32'h8000_1200, 7'h48, 4'hD, 32'h600, 1'b0, 15, 0, 1'b0);

    // fill_start held high across a fill, then back-to-back
    rises = n_req_rise;
    run_fill(32'h0000_3004, 2'd1, 32'h0000_3000, 7'h40, 4'd1, 32'h700, 1'b0, 15, 0, 1'b1);
    run_fill(32'h0000_3088, 2'd2, 32'h0000_3080, 7'h42, 4'd2, 32'h800, 1'b0, 15, 1, 1'b0);
    chk("one_req_per_fill", n_req_rise - rises, 2);

    // requested word 15 forwarded together with the write
    run_fill(32'h0000_2A7C, 2'd1, 32'h0000_2A40, 7'h29, 4'hF, 32'h900, 1'b0, 15, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("left_req", exp_req.size(), 0);
    chk("left_cpu", exp_cpu.size(), 0);
    chk("left_write", exp_wr.size(), 0);
    chk("left_error", pend_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
